// File: rtl/final_fpga_mem_fill_check_if.sv
`default_nettype none
// ============================================================================
//  Module      : final_fpga_mem_fill_check_if
//  Description : Avalon-MM word bus between the fill/check master and the
//                on-chip RAM slave port.
//  Revision    : 1.0 - initial release
// ============================================================================
interface final_fpga_mem_fill_check_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   m_address;
    logic                m_chipselect;
    logic                m_write;
    logic                m_read;
    logic [DATA_W-1:0]   m_writedata;
    logic [DATA_W/8-1:0] m_byteenable;
    logic [DATA_W-1:0]   m_readdata;
    logic                m_waitrequest;
    logic                m_readdatavalid;

    modport master (
        output m_address,
        output m_chipselect,
        output m_write,
        output m_read,
        output m_writedata,
        output m_byteenable,
        input  m_readdata,
        input  m_waitrequest,
        input  m_readdatavalid
    );

    modport slave (
        input  m_address,
        input  m_chipselect,
        input  m_write,
        input  m_read,
        input  m_writedata,
        input  m_byteenable,
        output m_readdata,
        output m_waitrequest,
        output m_readdatavalid
    );
endinterface
`default_nettype wire

// File: rtl/final_fpga_mem_fill_check.sv
`default_nettype none
// ============================================================================
//  Module      : final_fpga_mem_fill_check
//  Description : Avalon-MM master that fills a RAM word range with a
//                deterministic pattern and/or reads it back, counting
//                mismatches (saturating) and capturing the first bad address.
//                Build option FILL_LFSR_EN: pattern is a Galois LFSR sequence
//                instead of an incrementing count.
//  Revision    : 1.0 - initial release
// ============================================================================
module final_fpga_mem_fill_check #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int ERR_W  = 16
) (
    input  wire                 clk,
    input  wire                 reset,
    input  wire                 start,
    input  wire [1:0]           mode,
    input  wire [ADDR_W-1:0]    base_addr,
    input  wire [ADDR_W:0]      word_count,
    input  wire [DATA_W-1:0]    seed,
    output logic                busy,
    output logic                done,
    output logic [ERR_W-1:0]    error_count,
    output logic                first_err_valid,
    output logic [ADDR_W-1:0]   first_err_addr,
    final_fpga_mem_fill_check_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_RD_REQ  = 3'd2,
        S_RD_WAIT = 3'd3,
        S_FIN     = 3'd4
    } state_t;

    localparam logic [1:0] c_MODE_VERIFY      = 2'b01;
    localparam logic [1:0] c_MODE_FILL_VERIFY = 2'b10;

`ifdef FILL_LFSR_EN
    localparam logic [DATA_W-1:0] c_LFSR_POLY = DATA_W'(32'hA300_0000);
`endif

    // First pattern word for a given seed.
    function automatic logic [DATA_W-1:0] pat_first(input logic [DATA_W-1:0] s);
`ifdef FILL_LFSR_EN
        // An all-zero LFSR would lock up, so a zero seed starts at 1.
        pat_first = (s == '0) ? DATA_W'(1) : s;
`else
        pat_first = s;
`endif
    endfunction

    // Pattern word following p.
    function automatic logic [DATA_W-1:0] pat_next(input logic [DATA_W-1:0] p);
`ifdef FILL_LFSR_EN
        pat_next = (p >> 1) ^ (p[0] ? c_LFSR_POLY : '0);
`else
        pat_next = p + DATA_W'(1);
`endif
    endfunction

    state_t              state_q,           state_d;
    logic [1:0]          mode_q,            mode_d;
    logic [ADDR_W-1:0]   base_q,            base_d;
    logic [ADDR_W:0]     count_q,           count_d;
    logic [DATA_W-1:0]   seed_q,            seed_d;
    logic [ADDR_W:0]     idx_q,             idx_d;
    logic [DATA_W-1:0]   pat_q,             pat_d;
    logic                busy_q,            busy_d;
    logic                done_q,            done_d;
    logic [ERR_W-1:0]    error_count_q,     error_count_d;
    logic                first_err_valid_q, first_err_valid_d;
    logic [ADDR_W-1:0]   first_err_addr_q,  first_err_addr_d;
    logic [ADDR_W-1:0]   m_address_q,       m_address_d;
    logic                m_chipselect_q,    m_chipselect_d;
    logic                m_write_q,         m_write_d;
    logic                m_read_q,          m_read_d;
    logic [DATA_W-1:0]   m_writedata_q,     m_writedata_d;

    logic                rd_hit;
    logic [ADDR_W:0]     w_idx_inc;
    logic                w_last;
    logic [ADDR_W-1:0]   w_cur_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   w_pat_nxt;
    logic                w_mismatch;
    logic [ERR_W-1:0]    w_err_inc;

    // Index/address arithmetic; addresses wrap naturally at ADDR_W bits.
    assign w_idx_inc  = idx_q + (ADDR_W+1)'(1);
    assign w_last     = (w_idx_inc == count_q);
    assign w_cur_addr = base_q + idx_q[ADDR_W-1:0];
    assign w_addr_nxt = base_q + w_idx_inc[ADDR_W-1:0];
    assign w_pat_nxt  = pat_next(pat_q);
    assign w_mismatch = (bus.m_readdata != pat_q);
    assign w_err_inc  = (error_count_q == {ERR_W{1'b1}}) ? error_count_q
                                                         : error_count_q + ERR_W'(1);

    // Next-state and next-output computation for the fill/verify sequencer.
    always_comb begin
        state_d           = state_q;
        mode_d            = mode_q;
        base_d            = base_q;
        count_d           = count_q;
        seed_d            = seed_q;
        idx_d             = idx_q;
        pat_d             = pat_q;
        busy_d            = busy_q;
        done_d            = 1'b0;
        error_count_d     = error_count_q;
        first_err_valid_d = first_err_valid_q;
        first_err_addr_d  = first_err_addr_q;
        m_address_d       = m_address_q;
        m_chipselect_d    = m_chipselect_q;
        m_write_d         = m_write_q;
        m_read_d          = m_read_q;
        m_writedata_d     = m_writedata_q;
        rd_hit            = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d            = mode;
                    base_d            = base_addr;
                    count_d           = word_count;
                    seed_d            = seed;
                    idx_d             = '0;
                    pat_d             = pat_first(seed);
                    error_count_d     = '0;
                    first_err_valid_d = 1'b0;
                    first_err_addr_d  = '0;
                    m_address_d       = base_addr;
                    m_writedata_d     = pat_first(seed);
                    if (word_count == '0) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end else if (mode == c_MODE_VERIFY) begin
                        state_d        = S_RD_REQ;
                        busy_d         = 1'b1;
                        m_read_d       = 1'b1;
                        m_chipselect_d = 1'b1;
                    end else begin
                        // Reserved mode 11 falls through to a plain fill.
                        state_d        = S_WR;
                        busy_d         = 1'b1;
                        m_write_d      = 1'b1;
                        m_chipselect_d = 1'b1;
                    end
                end
            end

            S_WR: begin
                if (!bus.m_waitrequest) begin
                    if (w_last) begin
                        if (mode_q == c_MODE_FILL_VERIFY) begin
                            // Restart the pattern from the seed for the read-back pass.
                            state_d     = S_RD_REQ;
                            idx_d       = '0;
                            pat_d       = pat_first(seed_q);
                            m_address_d = base_q;
                            m_write_d   = 1'b0;
                            m_read_d    = 1'b1;
                        end else begin
                            state_d        = S_FIN;
                            busy_d         = 1'b0;
                            done_d         = 1'b1;
                            m_write_d      = 1'b0;
                            m_chipselect_d = 1'b0;
                        end
                    end else begin
                        idx_d         = w_idx_inc;
                        pat_d         = w_pat_nxt;
                        m_address_d   = w_addr_nxt;
                        m_writedata_d = w_pat_nxt;
                    end
                end
            end

            S_RD_REQ: begin
                if (!bus.m_waitrequest) begin
                    if (bus.m_readdatavalid) begin
                        // Zero-latency slave: data arrives with the acceptance.
                        rd_hit = 1'b1;
                    end else begin
                        state_d        = S_RD_WAIT;
                        m_read_d       = 1'b0;
                        m_chipselect_d = 1'b0;
                    end
                end
            end

            S_RD_WAIT: begin
                if (bus.m_readdatavalid) begin
                    rd_hit = 1'b1;
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Read data returned: score it and advance to the next word or finish.
        if (rd_hit) begin
            if (w_mismatch) begin
                error_count_d = w_err_inc;
                if (!first_err_valid_q) begin
                    first_err_valid_d = 1'b1;
                    first_err_addr_d  = w_cur_addr;
                end
            end
            if (w_last) begin
                state_d        = S_FIN;
                busy_d         = 1'b0;
                done_d         = 1'b1;
                m_read_d       = 1'b0;
                m_chipselect_d = 1'b0;
            end else begin
                state_d        = S_RD_REQ;
                idx_d          = w_idx_inc;
                pat_d          = w_pat_nxt;
                m_address_d    = w_addr_nxt;
                m_read_d       = 1'b1;
                m_chipselect_d = 1'b1;
            end
        end
    end

    // State and registered outputs; reset clears everything and aborts any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= S_IDLE;
            mode_q            <= '0;
            base_q            <= '0;
            count_q           <= '0;
            seed_q            <= '0;
            idx_q             <= '0;
            pat_q             <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            error_count_q     <= '0;
            first_err_valid_q <= 1'b0;
            first_err_addr_q  <= '0;
            m_address_q       <= '0;
            m_chipselect_q    <= 1'b0;
            m_write_q         <= 1'b0;
            m_read_q          <= 1'b0;
            m_writedata_q     <= '0;
        end else begin
            state_q           <= state_d;
            mode_q            <= mode_d;
            base_q            <= base_d;
            count_q           <= count_d;
            seed_q            <= seed_d;
            idx_q             <= idx_d;
            pat_q             <= pat_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            error_count_q     <= error_count_d;
            first_err_valid_q <= first_err_valid_d;
            first_err_addr_q  <= first_err_addr_d;
            m_address_q       <= m_address_d;
            m_chipselect_q    <= m_chipselect_d;
            m_write_q         <= m_write_d;
            m_read_q          <= m_read_d;
            m_writedata_q     <= m_writedata_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign error_count      = error_count_q;
    assign first_err_valid  = first_err_valid_q;
    assign first_err_addr   = first_err_addr_q;
    assign bus.m_address    = m_address_q;
    assign bus.m_chipselect = m_chipselect_q;
    assign bus.m_write      = m_write_q;
    assign bus.m_read       = m_read_q;
    assign bus.m_writedata  = m_writedata_q;
    assign bus.m_byteenable = '1;

endmodule
`default_nettype wire

// File: tb/tb_final_fpga_mem_fill_check.sv
`default_nettype none
// ============================================================================
//  Module      : tb_final_fpga_mem_fill_check
//  Description : Randomized bench for final_fpga_mem_fill_check with an
//                Avalon RAM slave (random stalls / read latency) and a
//                list-based reference model of writes, reads and results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_final_fpga_mem_fill_check;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int ERR_W  = 4;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [1:0]        mode = 2'b00;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   word_count = '0;
    logic [DATA_W-1:0] seed = '0;
    logic              busy;
    logic              done;
    logic [ERR_W-1:0]  error_count;
    logic              first_err_valid;
    logic [ADDR_W-1:0] first_err_addr;

    final_fpga_mem_fill_check_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    final_fpga_mem_fill_check #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ERR_W(ERR_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .mode            (mode),
        .base_addr       (base_addr),
        .word_count      (word_count),
        .seed            (seed),
        .busy            (busy),
        .done            (done),
        .error_count     (error_count),
        .first_err_valid (first_err_valid),
        .first_err_addr  (first_err_addr),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // RAM seen by the DUT, the model's idea of it, and read-corruption marks
    logic [31:0] mem     [DEPTH];
    logic [31:0] exp_mem [DEPTH];
    bit          bad     [DEPTH];

    // expected bus traffic, consumed by the slave
    int          exp_wr_a[$];
    logic [31:0] exp_wr_d[$];
    int          exp_rd_a[$];

    // slave behaviour knobs
    int stall_max   = 0;
    int stall_fixed = -1;
    int lat_min     = 0;
    int lat_max     = 0;
    bit spurious_en = 1'b0;

    function automatic logic [31:0] rd_val(input int a);
        return bad[a] ? 32'h0000_DEAD : mem[a];
    endfunction

    // Avalon RAM slave: drives its outputs on the falling edge
    initial begin
        bit          pend = 0;
        int          cnt = 0;
        int          pend_a = 0;
        bit          req_seen = 0;
        int          stall_left = 0;
        int          s_a = 0;
        logic [31:0] s_d = '0;
        logic [1:0]  s_ctl = '0;
        int          lat;
        int          a;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        bus.m_waitrequest   = 1'b0;
        bus.m_readdatavalid = 1'b0;
        bus.m_readdata      = '0;
        forever begin
            @(negedge clk);
            bus.m_readdatavalid = 1'b0;
            if (reset) begin
                pend = 0;
                req_seen = 0;
                bus.m_waitrequest = 1'b0;
                continue;
            end
            check("cs_matches_req", bus.m_chipselect, bus.m_write | bus.m_read);
            check("byteenable", bus.m_byteenable, 4'hF);
            if (pend) begin
                if (cnt == 0) begin
                    bus.m_readdatavalid = 1'b1;
                    bus.m_readdata = rd_val(pend_a);
                    pend = 0;
                end else cnt--;
            end
            if (bus.m_write || bus.m_read) begin
                a = int'(bus.m_address);
                if (!req_seen) begin
                    req_seen = 1;
                    stall_left = (stall_fixed >= 0) ? stall_fixed : int'($urandom_range(0, stall_max));
                    s_a = a; s_d = bus.m_writedata; s_ctl = {bus.m_write, bus.m_read};
                end else begin
                    check("hold_addr", a, s_a);
                    check("hold_ctl", {bus.m_write, bus.m_read}, s_ctl);
                    if (bus.m_write) check("hold_data", bus.m_writedata, s_d);
                end
                if (stall_left > 0) begin
                    stall_left--;
                    bus.m_waitrequest = 1'b1;
                end else begin
                    bus.m_waitrequest = 1'b0;
                    req_seen = 0;
                    if (bus.m_write) begin
                        mem[a] = bus.m_writedata;
                        check("wr_expected", exp_wr_a.size() != 0, 1);
                        if (exp_wr_a.size() != 0) begin
                            check("wr_addr", a, exp_wr_a.pop_front());
                            check("wr_data", bus.m_writedata, exp_wr_d.pop_front());
                        end
                    end else begin
                        check("rd_expected", exp_rd_a.size() != 0, 1);
                        if (exp_rd_a.size() != 0) check("rd_addr", a, exp_rd_a.pop_front());
                        lat = int'($urandom_range(lat_min, lat_max));
                        if (lat == 0) begin
                            bus.m_readdatavalid = 1'b1;
                            bus.m_readdata = rd_val(a);
                        end else begin
                            pend = 1; cnt = lat - 1; pend_a = a;
                        end
                    end
                end
            end else begin
                bus.m_waitrequest = 1'($urandom_range(0, 1));
            end
            // stray valid strobes while no read is in flight must be ignored
            if (spurious_en && !pend && !bus.m_readdatavalid && !bus.m_read && $urandom_range(0, 3) == 0) begin
                bus.m_readdatavalid = 1'b1;
                bus.m_readdata = $urandom;
            end
        end
    end

    // One operation: build the model's expectations, run, then check results.
    task automatic run_op(input logic [1:0] md, input int b, input int cnt, input logic [31:0] sd,
                          input int nbad, input int bad_at, input int exp_cyc, input bit poke);
        logic [31:0] pats[$];
        logic [31:0] p;
        logic [31:0] v;
        int  exp_err = 0;
        bit  exp_fv = 0;
        int  exp_fa = 0;
        int  a;
        int  cyc;
        int  limit;
        bit  do_wr = (md != 2'b01);
        bit  do_rd = (md == 2'b01) || (md == 2'b10);

`ifdef FILL_LFSR_EN
        p = (sd == 0) ? 32'd1 : sd;
        for (int i = 0; i < cnt; i++) begin
            pats.push_back(p);
            p = {1'b0, p[31:1]} ^ (p[0] ? 32'hA300_0000 : 32'h0);
        end
`else
        for (int i = 0; i < cnt; i++) pats.push_back(sd + 32'(i));
`endif
        for (int i = 0; i < DEPTH; i++) bad[i] = 0;
        if (cnt > 0) for (int k = 0; k < nbad; k++) bad[(b + int'($urandom_range(0, cnt - 1))) % DEPTH] = 1;
        if (bad_at >= 0) bad[bad_at] = 1;
        if (do_wr) for (int i = 0; i < cnt; i++) begin
            a = (b + i) % DEPTH;
            exp_wr_a.push_back(a);
            exp_wr_d.push_back(pats[i]);
            exp_mem[a] = pats[i];
        end
        if (do_rd) for (int i = 0; i < cnt; i++) begin
            a = (b + i) % DEPTH;
            exp_rd_a.push_back(a);
            v = bad[a] ? 32'h0000_DEAD : exp_mem[a];
            if (v != pats[i]) begin
                exp_err++;
                if (!exp_fv) begin exp_fv = 1; exp_fa = a; end
            end
        end
        if (exp_err > ERR_MAX) exp_err = ERR_MAX;

        @(posedge clk); #1;
        mode = md; base_addr = ADDR_W'(b); word_count = (ADDR_W+1)'(cnt); seed = sd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, cnt > 0);
        limit = cnt * 16 + 40;
        cyc = 1;
        while (!done && cyc < limit) begin
            if (poke && cyc == 2) begin
                mode = 2'b00; base_addr = ~ADDR_W'(b); word_count = 1; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        check("done_seen", done, 1'b1);
        if (!done) return;
        check("busy_at_done", busy, 1'b0);
        check("error_count", error_count, exp_err);
        check("first_err_valid", first_err_valid, exp_fv);
        if (exp_fv) check("first_err_addr", first_err_addr, exp_fa);
        if (exp_cyc >= 0) check("op_cycles", cyc, exp_cyc);
        check("writes_left", exp_wr_a.size(), 0);
        check("reads_left", exp_rd_a.size(), 0);
        exp_wr_a.delete(); exp_wr_d.delete(); exp_rd_a.delete();
        // a start during the done cycle must be ignored
        mode = 2'b00; word_count = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("fin_start_ignored", done, 1'b0);
        check("idle_after_done", busy, 1'b0);
    endtask

    // Reset while a read is outstanding, then a normal run.
    task automatic reset_in_rd_wait();
        int k;
        stall_fixed = 0; lat_min = 4; lat_max = 4; spurious_en = 0;
        for (int i = 0; i < 5; i++) exp_rd_a.push_back(16'h40 + i);
        @(posedge clk); #1;
        mode = 2'b01; base_addr = 13'h40; word_count = 5; seed = 32'h55; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (!(busy && !bus.m_read) && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("reached_rd_wait", busy && !bus.m_read, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_busy", busy, 1'b0);
        check("rst_read", bus.m_read, 1'b0);
        check("rst_write", bus.m_write, 1'b0);
        check("rst_cs", bus.m_chipselect, 1'b0);
        check("rst_done", done, 1'b0);
        reset = 1'b0;
        exp_rd_a.delete();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("no_done_after_rst", done, 1'b0);
        end
        lat_min = 0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin exp_mem[i] = '0; bad[i] = 0; end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_m_read", bus.m_read, 0);
        check("rst_m_write", bus.m_write, 0);
        check("rst_m_cs", bus.m_chipselect, 0);
        check("rst_err", error_count, 0);
        check("rst_fev", first_err_valid, 0);
        check("rst_fea", first_err_addr, 0);
        check("rst_addr", bus.m_address, 0);
        check("rst_wdata", bus.m_writedata, 0);
        reset = 1'b0;

        // fill then verify, clean
        stall_fixed = 0; lat_min = 0; lat_max = 2;
        run_op(2'b10, 'h100, 4, 32'h1000, 0, -1, -1, 0);
`ifndef FILL_LFSR_EN
        check("t1_mem_102", mem['h102], 32'h1002);
`endif
        // same, word 0x102 reads back as 0xDEAD
        run_op(2'b10, 'h100, 4, 32'h1000, 0, 'h102, -1, 0);
        // wrap-around fill with two wait states per write
        stall_fixed = 2;
        run_op(2'b00, 'h1FFE, 4, 32'hCAFE_0000, 0, -1, 13, 0);
        stall_fixed = 0;
        // zero words, and a fill with back-to-back writes and a start while busy
        run_op(2'b00, 'h20, 0, 32'h1, 0, -1, 1, 0);
        run_op(2'b00, 'h300, 6, 32'h77, 0, -1, 7, 1);
        // verify-only of that range, then of it with corruption and mode 11
        run_op(2'b01, 'h300, 6, 32'h77, 0, -1, -1, 0);
        run_op(2'b01, 'h300, 6, 32'h77, 2, -1, -1, 0);
        run_op(2'b11, 'h400, 3, 32'h9, 0, -1, 4, 0);
`ifdef FILL_LFSR_EN
        run_op(2'b00, 'h500, 3, 32'h0, 0, -1, 4, 0);
        check("lfsr_w0", mem['h500], 32'h0000_0001);
        check("lfsr_w1", mem['h501], 32'hA300_0000);
        check("lfsr_w2", mem['h502], 32'h5180_0000);
`endif
        reset_in_rd_wait();
        run_op(2'b10, 'h40, 5, 32'h55, 0, -1, -1, 0);
        // whole RAM, fill and read back once
        lat_max = 1;
        run_op(2'b00, 'h0ABC, DEPTH, 32'h1234_5678, 0, -1, DEPTH + 1, 0);
        run_op(2'b01, 'h0ABC, DEPTH, 32'h1234_5678, 3, -1, -1, 0);
        // randomized operations with stalls, latency and stray valids
        stall_fixed = -1; spurious_en = 1;
        for (int t = 0; t < 30; t++) begin
            stall_max = int'($urandom_range(0, 2));
            lat_max   = int'($urandom_range(0, 3));
            run_op(2'($urandom_range(0, 3)), int'($urandom_range(0, DEPTH - 1)),
                   ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40)),
                   $urandom, int'($urandom_range(0, 20)), -1, -1, t[0]);
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
